// File: rtl/ebi_arbiter_pkg.sv
// Shared constants for the EBI arbiter and its neighbours.
//   - FSM state encodings (legacy 2-bit constants)
//   - default EBI strobe timing
//   - active-low strobe levels, also used by the UART-EBI bridge
//   - wrap_inc: modulo increment used for the round-robin pointer
package ebi_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD      = 2'd1;
  localparam logic [1:0] ST_WR      = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam int EBI_RD_WAIT   = 8;
  localparam int EBI_WR_CYCLES = 1;
  localparam int EBI_RECOVER   = 1;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/ebi_arbiter_if.sv
// Requester handshake plus EBI pin bundle for the arbiter.
//   slave  : arbiter view (takes requests, drives the EBI pins)
//   master : requester/bus-device view (the opposite directions)
// Requester i occupies slice [i*W +: W] of the packed addr/wdata vectors.
interface ebi_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      ebi_cs;
  logic                      ebi_rden;
  logic                      ebi_wren;
  logic [ADDR_W-1:0]         ebi_addr;
  logic [DATA_W-1:0]         ebi_dout;
  logic [DATA_W-1:0]         ebi_din;
  logic                      busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ebi_din,
    output req_ready, rsp_valid, rsp_rdata, ebi_cs, ebi_rden, ebi_wren,
           ebi_addr, ebi_dout, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ebi_din,
    input  req_ready, rsp_valid, rsp_rdata, ebi_cs, ebi_rden, ebi_wren,
           ebi_addr, ebi_dout, busy
  );
endinterface

// File: rtl/ebi_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req : pending request bits
//   ptr : highest-priority requester index this round
//   gnt : one-hot grant (zero when nothing pending)
//   idx : index of the granted requester
module ebi_arbiter_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the farthest offset down to ptr so the nearest pending
  // requester (offset 0 = ptr itself) is the last, winning assignment.
  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ebi_arbiter.sv
// Shares one EBI slave bus between NUM_REQ masters, one single-word access
// at a time, round-robin. Sequences active-low cs/rden/wren with programmed
// strobe widths and a recovery gap; returns a one-cycle completion pulse
// (and read data) to the granted requester.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester handshake + EBI pins (ebi_arbiter_if.slave)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no access; grant at the first edge with any req_valid
// ST_RD      | cs/rden low, RD_WAIT+1 cycles from the grant edge
// ST_WR      | cs/wren low, WR_CYCLES cycles from the grant edge
// ST_RECOVER | all strobes high for RECOVER cycles; may grant at its end
module ebi_arbiter
  import ebi_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_WAIT   = EBI_RD_WAIT,
  parameter int WR_CYCLES = EBI_WR_CYCLES,
  parameter int RECOVER   = EBI_RECOVER
) (
  input logic          clk,
  input logic          rst,
  ebi_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [1:0]         state;
  logic [7:0]         cnt;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               can_grant;

  ebi_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // The last RECOVER cycle behaves like IDLE so the next grant lands exactly
  // RECOVER cycles after strobe deassertion.
  assign can_grant = (state == ST_IDLE) || (state == ST_RECOVER && cnt == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= 8'd0;
      ptr           <= '0;
      gnt_q         <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.ebi_cs    <= STROBE_OFF;
      bus.ebi_rden  <= STROBE_OFF;
      bus.ebi_wren  <= STROBE_OFF;
      bus.ebi_addr  <= '0;
      bus.ebi_dout  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      if (can_grant && |bus.req_valid) begin
        gnt_q         <= pick_gnt;
        bus.req_ready <= pick_gnt;
        ptr           <= IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
        bus.ebi_addr  <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
        bus.ebi_dout  <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
        bus.ebi_cs    <= STROBE_ON;
        bus.busy      <= 1'b1;
        if (bus.req_we[pick_idx]) begin
          bus.ebi_wren <= STROBE_ON;
          state        <= ST_WR;
          cnt          <= 8'(WR_CYCLES - 1);
        end else begin
          bus.ebi_rden <= STROBE_ON;
          state        <= ST_RD;
          cnt          <= 8'(RD_WAIT);
        end
      end else begin
        case (state)
          ST_RD: begin
            if (cnt == 8'd0) begin
              bus.rsp_rdata <= bus.ebi_din;
              bus.ebi_cs    <= STROBE_OFF;
              bus.ebi_rden  <= STROBE_OFF;
              bus.rsp_valid <= gnt_q;
              state         <= ST_RECOVER;
              cnt           <= 8'(RECOVER - 1);
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          ST_WR: begin
            if (cnt == 8'd0) begin
              bus.ebi_cs    <= STROBE_OFF;
              bus.ebi_wren  <= STROBE_OFF;
              bus.rsp_valid <= gnt_q;
              state         <= ST_RECOVER;
              cnt           <= 8'(RECOVER - 1);
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          ST_RECOVER: begin
            if (cnt == 8'd0) begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ebi_arbiter.md
Name: ebi_arbiter

Overview:
- Shares one external EBI slave bus between NUM_REQ independent masters, e.g. the UART command bridge and an on-chip sequencer/DMA.
- Accepts one single-word read or write request at a time, picking among pending requests round-robin.
- Sequences the active-low cs/rden/wren strobes with programmed strobe widths and a recovery gap.
- Returns a one-cycle completion pulse, plus read data for reads, to the requester that was granted.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 16, EBI address width.
- DATA_W, 16, EBI data width.
- RD_WAIT, 8, extra read-strobe cycles; read strobe is RD_WAIT+1 cycles (0..255).
- WR_CYCLES, 1, write-strobe length in cycles (1..255).
- RECOVER, 1, idle cycles with cs high between accesses (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data of the last completed read (shared)
- ebi_cs  out  1  chip select, active-low
- ebi_rden  out  1  read strobe, active-low
- ebi_wren  out  1  write strobe, active-low
- ebi_addr  out  ADDR_W  bus address
- ebi_dout  out  DATA_W  bus write data
- ebi_din  in  DATA_W  bus read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - ebi_cs, ebi_rden, ebi_wren = 1.
  - ebi_addr, ebi_dout, rsp_rdata = 0.
  - req_ready, rsp_valid = 0; busy = 0.
  - State = IDLE, round-robin pointer = 0, counter = 0.
- Reset mid-access: strobes deassert at once; no rsp_valid is issued; the request is lost.
- All outputs are registered.
- States: IDLE, RD, WR, RECOVER.
- IDLE, at the first edge where any req_valid is high:
  - Grant g = the first set bit scanning from ptr upward, wrapping modulo NUM_REQ.
  - Latch addr/wdata/we of g; drive ebi_addr/ebi_dout; ebi_cs = 0.
  - Read: ebi_rden = 0, go to RD. Write: ebi_wren = 0, go to WR.
  - req_ready[g] = 1 for exactly that next cycle; ptr <= (g+1) mod NUM_REQ.
  - No grant if every req_valid is low at the edge.
- Requester rules:
  - Keep req_valid and all fields stable until req_ready.
  - Drop req_valid in the cycle req_ready is seen, or issue a new request.
  - req_valid still high in the first RECOVER cycle is treated as a new request.
- RD:
  - Strobe held low for RD_WAIT+1 cycles, counted from the grant edge.
  - At the last edge: sample ebi_din into rsp_rdata, set ebi_cs/ebi_rden = 1, rsp_valid[g] = 1 for one cycle, go to RECOVER.
- WR:
  - Strobe held low for WR_CYCLES cycles.
  - Then ebi_cs/ebi_wren = 1, rsp_valid[g] = 1 for one cycle, go to RECOVER.
  - rsp_rdata is unchanged by writes.
- RECOVER:
  - Stays for RECOVER cycles with all strobes high, then returns to IDLE.
  - The earliest next grant edge is RECOVER cycles after strobe deassertion.
- Strobes are mutually exclusive: ebi_rden and ebi_wren are never both 0.
- ebi_addr and ebi_dout stay constant while ebi_cs = 0, and hold their last value when idle.
- Simultaneous requests are served in round-robin order; with NUM_REQ = 2 and both always pending, grants alternate 0,1,0,1.
- A request arriving during an access waits; there is no preemption.
- Counter is 8 bits and saturates logic-free because the parameter ranges are bounded.

Decomposition:
- Shared package/include ebi_pkg:
  - State encoding constants.
  - EBI default timing constants (RD_WAIT = 8, WR_CYCLES = 1, RECOVER = 1).
  - Active-low strobe level constants, shared with the UART-EBI bridge.
- One sub-module, rr_pick:
  - Combinational round-robin selector.
  - Inputs: req vector and ptr. Outputs: one-hot grant and index.

Test Plan:
- Read path: after reset, req 0 reads addr 0x1234, ebi_din = 0xBEEF → ebi_cs/ebi_rden low exactly 9 cycles with ebi_addr = 0x1234; req_ready[0] pulses on cycle 1; rsp_valid[0] pulses once; rsp_rdata = 0xBEEF.
- Write path: req 1 writes 0x00A5 to 0x0042 → ebi_wren low exactly 1 cycle; ebi_dout = 0x00A5 and ebi_addr = 0x0042 throughout; ebi_rden stays 1; rsp_valid[1] pulses; rsp_rdata unchanged.
- Contention: req 0 and req 1 held continuously, 4 accesses each → grant order 0,1,0,1,...; at least 1 cycle with cs high between accesses; no strobe overlap.
- Back-to-back: same requester issues 3 reads with req_valid re-raised immediately → each access separated by RECOVER cycles; 3 rsp pulses in order with the correct data.
- Reset mid-read: assert rst 3 cycles into a read → cs/rden high immediately; no rsp_valid; after release, a fresh write completes normally with ptr = 0.
- Parameter sweep: RD_WAIT = 0, WR_CYCLES = 3, RECOVER = 4 → read strobe 1 cycle, write strobe 3 cycles, 4-cycle gaps.
